// File: rtl/sram_fifo_pkg.sv
// Shared defaults and small helpers for the SRAM-backed latency FIFO.
// Counter sizing and wrap arithmetic live here so non-power-of-2 depths are handled in one place.
package sram_fifo_pkg;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_DEPTH   = 8;
  localparam int unsigned DEF_LATENCY = 5;

  // Bits needed to hold every value from 0 up to and including max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Pointer increment with an explicit wrap, valid for any depth >= 1.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sram_fifo_obuf.sv
// Small synchronous circular buffer that catches SRAM read returns.
// Callers guarantee no write when full and no read when empty.
module sram_fifo_obuf
  import sram_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_LATENCY + 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign rd_data = mem[rd_ptr];

  // NOTE: storage has no reset; count/empty gate every read, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses <= so every register sees pre-edge values of its neighbours.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= PTR_W'(wrap_inc(32'(wr_ptr), DEPTH));
      if (rd_en) rd_ptr <= PTR_W'(wrap_inc(32'(rd_ptr), DEPTH));
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Credit accounting upstream must make these impossible.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(wr_en && full && !rd_en));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(rd_en && empty));

endmodule

// File: rtl/sram_latency_fifo_ctrl.sv
// FIFO controller wrapped around a fixed-latency dual-port SRAM: push side writes the SRAM,
// credit-limited reads stream into a small output buffer that feeds the pop side.
module sram_latency_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned LATENCY    = DEF_LATENCY,
  parameter int unsigned OBUF_DEPTH = LATENCY + 2,
  parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_vld_i,
  output logic              push_rdy_o,
  input  logic [WIDTH-1:0]  push_data_i,
  output logic              pop_vld_o,
  input  logic              pop_rdy_i,
  output logic [WIDTH-1:0]  pop_data_o,
  output logic              sram_wen_o,
  output logic [ADDR_W-1:0] sram_waddr_o,
  output logic [WIDTH-1:0]  sram_wdata_o,
  output logic              sram_ren_o,
  output logic [ADDR_W-1:0] sram_raddr_o,
  input  logic [WIDTH-1:0]  sram_rdata_i,
  input  logic              sram_vld_i
);

  localparam int unsigned CNT_W   = cnt_width(DEPTH);
  localparam int unsigned CRD_W   = cnt_width(OBUF_DEPTH);
  localparam int unsigned FLUSH_W = cnt_width(LATENCY);

  logic [ADDR_W-1:0]  wptr;
  logic [ADDR_W-1:0]  rptr;
  logic [CNT_W-1:0]   sram_cnt;
  logic [CNT_W-1:0]   sram_cnt_nxt;
  logic [CRD_W-1:0]   credits;
  logic [CRD_W-1:0]   credits_nxt;
  logic [FLUSH_W-1:0] flush_cnt;
  logic               flushing;
  logic               push_acc;
  logic               pop_hs;
  logic               capture;
  logic               obuf_empty;
  logic [WIDTH-1:0]   obuf_data;

  // After reset, returns still in the SRAM pipeline are stale; hold everything off until they drain.
  assign flushing = (flush_cnt != '0);

  assign push_rdy_o   = !flushing && (sram_cnt < CNT_W'(DEPTH));
  assign push_acc     = push_vld_i && push_rdy_o;
  assign sram_wen_o   = push_acc;
  assign sram_waddr_o = wptr;
  assign sram_wdata_o = push_acc ? push_data_i : '0;

  // A read is issued only when its return already has a reserved slot in the output buffer.
  assign sram_ren_o   = !flushing && (sram_cnt != '0) && (credits != '0);
  assign sram_raddr_o = rptr;

  assign capture    = sram_vld_i && !flushing;
  assign pop_vld_o  = !obuf_empty;
  assign pop_hs     = pop_vld_o && pop_rdy_i;
  assign pop_data_o = pop_vld_o ? obuf_data : '0;

  // NOTE: next-state values take their hold defaults first, so no path through the block infers a latch.
  always_comb begin
    sram_cnt_nxt = sram_cnt;
    credits_nxt  = credits;
    case ({push_acc, sram_ren_o})
      2'b10:   sram_cnt_nxt = sram_cnt + CNT_W'(1);
      2'b01:   sram_cnt_nxt = sram_cnt - CNT_W'(1);
      default: ;
    endcase
    case ({sram_ren_o, pop_hs})
      2'b10:   credits_nxt = credits - CRD_W'(1);
      2'b01:   credits_nxt = credits + CRD_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr      <= '0;
      rptr      <= '0;
      sram_cnt  <= '0;
      credits   <= CRD_W'(OBUF_DEPTH);
      flush_cnt <= FLUSH_W'(LATENCY);
    end else begin
      if (flushing)   flush_cnt <= flush_cnt - FLUSH_W'(1);
      if (push_acc)   wptr      <= ADDR_W'(wrap_inc(32'(wptr), DEPTH));
      if (sram_ren_o) rptr      <= ADDR_W'(wrap_inc(32'(rptr), DEPTH));
      sram_cnt <= sram_cnt_nxt;
      credits  <= credits_nxt;
    end
  end

  sram_fifo_obuf #(
    .WIDTH (WIDTH),
    .DEPTH (OBUF_DEPTH)
  ) u_obuf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .wr_en   (capture),
    .wr_data (sram_rdata_i),
    .rd_en   (pop_hs),
    .rd_data (obuf_data),
    .empty   (obuf_empty)
  );

  a_credit_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    credits <= CRD_W'(OBUF_DEPTH));
  a_sram_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    sram_cnt <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_sram_latency_fifo_ctrl.sv
// Directed bench for sram_latency_fifo_ctrl with a behavioural fixed-latency SRAM model
// and a stale-return injector; expected values are hand-derived per scenario.
module tb_sram_latency_fifo_ctrl;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 8;
  localparam int LATENCY = 5;
  localparam int OBUF    = LATENCY + 2;
  localparam int ADDR_W  = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              push_vld;
  logic              push_rdy_o;
  logic [WIDTH-1:0]  push_data;
  logic              pop_vld_o;
  logic              pop_rdy;
  logic [WIDTH-1:0]  pop_data_o;
  logic              sram_wen_o;
  logic [ADDR_W-1:0] sram_waddr_o;
  logic [WIDTH-1:0]  sram_wdata_o;
  logic              sram_ren_o;
  logic [ADDR_W-1:0] sram_raddr_o;
  logic [WIDTH-1:0]  sram_rdata;
  logic              sram_vld;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_latency_fifo_ctrl #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .LATENCY    (LATENCY),
    .OBUF_DEPTH (OBUF),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .push_vld_i   (push_vld),
    .push_rdy_o   (push_rdy_o),
    .push_data_i  (push_data),
    .pop_vld_o    (pop_vld_o),
    .pop_rdy_i    (pop_rdy),
    .pop_data_o   (pop_data_o),
    .sram_wen_o   (sram_wen_o),
    .sram_waddr_o (sram_waddr_o),
    .sram_wdata_o (sram_wdata_o),
    .sram_ren_o   (sram_ren_o),
    .sram_raddr_o (sram_raddr_o),
    .sram_rdata_i (sram_rdata),
    .sram_vld_i   (sram_vld)
  );

  // Behavioural SRAM: deliberately not reset, so in-flight reads survive a controller reset.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [LATENCY-1:0] pipe_vld;
  logic [WIDTH-1:0] pipe_data [LATENCY];
  logic             inj_vld;
  logic [WIDTH-1:0] inj_data;

  initial begin
    pipe_vld = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    for (int i = 0; i < LATENCY; i++) pipe_data[i] = '0;
  end

  always @(posedge clk) begin
    if (sram_wen_o) mem[sram_waddr_o] <= sram_wdata_o;
    pipe_vld     <= {pipe_vld[LATENCY-2:0], sram_ren_o};
    pipe_data[0] <= mem[sram_raddr_o];
    for (int i = 1; i < LATENCY; i++) pipe_data[i] <= pipe_data[i-1];
  end

  assign sram_vld   = pipe_vld[LATENCY-1] | inj_vld;
  assign sram_rdata = inj_vld ? inj_data : pipe_data[LATENCY-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: address sequence model, event counters and popped-data queue.
  int               exp_w, exp_r;
  int               n_acc, n_ren;
  logic [WIDTH-1:0] pop_q [$];

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_w = 0;
      exp_r = 0;
    end else begin
      if (sram_wen_o) begin
        check("waddr", 32'(sram_waddr_o), 32'(exp_w));
        exp_w = (exp_w == DEPTH - 1) ? 0 : exp_w + 1;
        n_acc++;
      end
      if (sram_ren_o) begin
        check("raddr", 32'(sram_raddr_o), 32'(exp_r));
        exp_r = (exp_r == DEPTH - 1) ? 0 : exp_r + 1;
        n_ren++;
      end
      if (pop_vld_o && pop_rdy) pop_q.push_back(pop_data_o);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_push_rdy"}, 32'(push_rdy_o), 0);
    check({tag, "_wen"},      32'(sram_wen_o), 0);
    check({tag, "_waddr"},    32'(sram_waddr_o), 0);
    check({tag, "_wdata"},    32'(sram_wdata_o), 0);
    check({tag, "_ren"},      32'(sram_ren_o), 0);
    check({tag, "_raddr"},    32'(sram_raddr_o), 0);
    check({tag, "_pop_vld"},  32'(pop_vld_o), 0);
    check({tag, "_pop_data"}, 32'(pop_data_o), 0);
  endtask

  // Fill with pop stalled, then drain and compare order.
  task automatic fill_drain(input logic [7:0] base, input int offer,
                            input int exp_acc, input int exp_ren);
    int sent;
    sent  = 0;
    n_acc = 0;
    n_ren = 0;
    pop_q.delete();
    pop_rdy = 1'b0;
    for (int c = 0; c < 30; c++) begin
      push_vld  = (sent < offer);
      push_data = 8'(base + 8'(sent));
      @(negedge clk);
      if (push_vld && push_rdy_o) sent++;
      next_cycle();
    end
    push_vld = 1'b0;
    check("fd_accepted", 32'(n_acc), 32'(exp_acc));
    check("fd_push_rdy_full", 32'(push_rdy_o), 0);
    check("fd_ren_pulses", 32'(n_ren), 32'(exp_ren));
    pop_rdy = 1'b1;
    for (int c = 0; c < 100 && pop_q.size() < exp_acc; c++) next_cycle();
    repeat (5) next_cycle();
    check("fd_pop_count", 32'(pop_q.size()), 32'(exp_acc));
    for (int k = 0; k < pop_q.size() && k < exp_acc; k++)
      check("fd_pop_data", 32'(pop_q[k]), 32'(8'(base + 8'(k))));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    push_vld  = 1'b0;
    push_data = '0;
    pop_rdy   = 1'b0;
    inj_vld   = 1'b0;
    inj_data  = '0;

    // Reset asserted: every output low, even with push data driven.
    repeat (2) @(posedge clk);
    push_data = 8'hFF;
    @(negedge clk);
    check_all_zero("rst");
    push_data = '0;

    // Release; flush holds push_rdy low for LATENCY cycles.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("flush_push_rdy", 32'(push_rdy_o), (k >= LATENCY) ? 1 : 0);
      check("flush_ren", 32'(sram_ren_o), 0);
      check("flush_pop_vld", 32'(pop_vld_o), 0);
      next_cycle();
    end

    // Cycle 10: single push of 0xA5.
    pop_rdy   = 1'b1;
    push_vld  = 1'b1;
    push_data = 8'hA5;
    @(negedge clk);
    check("single_wen", 32'(sram_wen_o), 1);
    check("single_waddr", 32'(sram_waddr_o), 0);
    check("single_wdata", 32'(sram_wdata_o), 32'h A5);
    next_cycle();
    push_vld = 1'b0;
    @(negedge clk);
    check("single_ren", 32'(sram_ren_o), 1);
    check("single_raddr", 32'(sram_raddr_o), 0);
    next_cycle();
    for (int c = 12; c < 17; c++) begin
      @(negedge clk);
      check("single_wait_vld", 32'(pop_vld_o), 0);
      next_cycle();
    end
    @(negedge clk);
    check("single_pop_vld", 32'(pop_vld_o), 1);
    check("single_pop_data", 32'(pop_data_o), 32'h A5);
    next_cycle();
    @(negedge clk);
    check("single_after_vld", 32'(pop_vld_o), 0);
    next_cycle();

    // Back-to-back stream: first pop 7 cycles after first push, then no bubbles.
    for (int i = 0; i < 40; i++) begin
      push_vld  = (i < 32);
      push_data = 8'(i);
      @(negedge clk);
      if (i < 32) check("stream_push_rdy", 32'(push_rdy_o), 1);
      if (i >= 7 && i < 39) begin
        check("stream_pop_vld", 32'(pop_vld_o), 1);
        check("stream_pop_data", 32'(pop_data_o), 32'(i - 7));
      end else begin
        check("stream_idle_vld", 32'(pop_vld_o), 0);
      end
      next_cycle();
    end
    push_vld = 1'b0;
    repeat (3) next_cycle();

    // Back-pressure: 20 offered, capacity DEPTH+OBUF = 15, credits allow 7 reads.
    fill_drain(8'h40, 20, DEPTH + OBUF, OBUF);

    // Three full fill/drain rounds exercising pointer wrap.
    fill_drain(8'h80, 15, 15, OBUF);
    fill_drain(8'hA0, 15, 15, OBUF);
    fill_drain(8'hC0, 15, 15, OBUF);
    check("idle_sram_cnt", 32'(dut.sram_cnt), 0);
    check("idle_credits", 32'(dut.credits), 32'(OBUF));
    check("idle_push_rdy", 32'(push_rdy_o), 1);
    check("idle_ren", 32'(sram_ren_o), 0);

    // Mid-stream reset with reads in flight.
    pop_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_vld  = 1'b1;
      push_data = 8'(8'h10 + 8'(i));
      next_cycle();
    end
    push_vld = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    next_cycle();
    rst_n    = 1'b1;
    inj_vld  = 1'b1;
    inj_data = 8'hEE;
    pop_q.delete();
    for (int k = 0; k < LATENCY; k++) begin
      @(negedge clk);
      check("stale_pop_vld", 32'(pop_vld_o), 0);
      check("stale_push_rdy", 32'(push_rdy_o), 0);
      next_cycle();
    end
    inj_vld = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_flush_vld", 32'(pop_vld_o), 0);
      next_cycle();
    end
    push_vld  = 1'b1;
    push_data = 8'h3C;
    @(negedge clk);
    check("recover_push_rdy", 32'(push_rdy_o), 1);
    next_cycle();
    push_vld = 1'b0;
    repeat (15) next_cycle();
    check("recover_pop_count", 32'(pop_q.size()), 1);
    if (pop_q.size() > 0) check("recover_pop_data", 32'(pop_q[0]), 32'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
